pattern_stream_gen: RTL and testbench

Serial stimulus source for the FSM pattern-detector family. It takes parallel words over a valid/ready handshake, shifts them out MSB-first as a one-bit `data_o` / `valid_o` stream, and on request inserts the marker sequence 11010 (B B C B C) between words. It sits upstream of the overlapping Mealy 11010 detector and drives that detector's `data_i` / `valid_i` pair directly. It also counts inserted markers so the downstream detector's hit count can be cross-checked.

---
 rtl/pattern_stream_gen_if.sv | 28 ++
 rtl/pattern_stream_gen.sv | 130 +++++++++++++
 tb/tb_pattern_stream_gen.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_stream_gen_if.sv
// Port bundle for pattern_stream_gen: parallel word input, inject request,
// serial stream output, status and FSM debug state.
interface pattern_stream_gen_if #(
  parameter int WIDTH = 8
);
  // Word handshake: a word transfers on a rising edge where valid_i & ready_o;
  // the source holds data_i stable and valid_i high until that edge, and
  // ready_o may depend combinationally on inject_i.
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             inject_i;
  logic             data_o;
  logic             valid_o;
  logic             busy_o;
  logic [7:0]       inj_count_o;
  logic [1:0]       dbg_state;

  modport master (
    output data_i, valid_i, inject_i,
    input  ready_o, data_o, valid_o, busy_o, inj_count_o, dbg_state
  );

  modport slave (
    input  data_i, valid_i, inject_i,
    output ready_o, data_o, valid_o, busy_o, inj_count_o, dbg_state
  );
endinterface

// File: rtl/pattern_stream_gen.sv
// Serialises parallel words MSB-first onto a 1-bit valid stream and inserts
// the 5-bit marker on request, counting completed markers.
module pattern_stream_gen #(
  parameter int         WIDTH   = 8,
  parameter logic [4:0] PATTERN = 5'b11010,
  parameter int         GAP     = 0
) (
  input logic               clk,
  input logic               rst,
  pattern_stream_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_D  = 2'd1,
    SHIFT_P  = 2'd2,
    GAP_WAIT = 2'd3
  } state_t;

  // The shifter must also hold the 5-bit marker when WIDTH < 5; both are left-aligned.
  localparam int SR_W = (WIDTH > 5) ? WIDTH : 5;
  localparam logic [SR_W-1:0] MARK_ALIGNED = SR_W'(PATTERN) << (SR_W - 5);

  state_t          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0] word_aligned;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic            inj_pend_q, inj_pend_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            data_q, valid_q;
  logic            data_d, valid_d;
  logic            last_bit, ready, take;

  assign word_aligned = SR_W'(bus.data_i) << (SR_W - WIDTH);
  assign last_bit     = ((state_q == SHIFT_D) || (state_q == SHIFT_P)) && (bit_cnt_q == 5'd0);
  assign take         = bus.valid_i && ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      gap_q      <= '0;
      inj_pend_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_q      <= gap_d;
      inj_pend_q <= inj_pend_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    inj_pend_d = inj_pend_q | bus.inject_i;
    case (state_q)
      IDLE: begin
        if (inj_pend_q) begin
          state_d    = SHIFT_P;
          sr_d       = MARK_ALIGNED;
          bit_cnt_d  = 5'd4;
          inj_pend_d = 1'b0;
        end else if (take) begin
          state_d   = SHIFT_D;
          sr_d      = word_aligned;
          bit_cnt_d = 5'(WIDTH - 1);
        end
      end
      SHIFT_D, SHIFT_P: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - 5'd1;
        if (bit_cnt_q == 5'd0) begin
          if ((state_q == SHIFT_P) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
          if (GAP > 0) begin
            state_d = GAP_WAIT;
            gap_d   = 4'(GAP);
          end else if (inj_pend_q || bus.inject_i) begin
            // A same-cycle inject is consumed here, so it never sets the flag.
            state_d    = SHIFT_P;
            sr_d       = MARK_ALIGNED;
            bit_cnt_d  = 5'd4;
            inj_pend_d = 1'b0;
          end else if (take) begin
            state_d   = SHIFT_D;
            sr_d      = word_aligned;
            bit_cnt_d = 5'(WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP_WAIT: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; ready is withheld on a last bit with a same-cycle inject,
  // because the marker wins that slot and the word must not be lost.
  always_comb begin
    ready   = rst && !inj_pend_q &&
              ((state_q == IDLE) || (last_bit && (GAP == 0) && !bus.inject_i));
    valid_d = (state_d == SHIFT_D) || (state_d == SHIFT_P);
    data_d  = valid_d && sr_d[SR_W-1];
  end

  assign bus.ready_o     = ready;
  assign bus.busy_o      = (state_q != IDLE) || inj_pend_q;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.inj_count_o = cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Bench for pattern_stream_gen: hand-derived vector table, directed corner
// sequences and random traffic against a bit-queue reference model.
module tb_pattern_stream_gen;

  logic clk;
  logic rst;

  pattern_stream_gen_if #(.WIDTH(8)) bus0 ();
  pattern_stream_gen_if #(.WIDTH(8)) bus2 ();

  pattern_stream_gen #(.WIDTH(8), .PATTERN(5'b11010), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pattern_stream_gen #(.WIDTH(8), .PATTERN(5'b11010), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each instance holds its current item as a bit vector
  // plus a remaining-bit count, a gap countdown, a pending flag and a count.
  logic [31:0] m_item[2];
  int          m_left[2];
  int          m_gap[2];
  int          m_cnt[2];
  bit          m_pend[2];
  bit          m_mark[2];
  logic [7:0]  exp_q[$];
  logic [7:0]  col0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_item[m] = '0; m_left[m] = 0; m_gap[m] = 0;
      m_cnt[m] = 0; m_pend[m] = 0; m_mark[m] = 0;
    end
    exp_q.delete();
    col0 = '0;
  endtask

  function automatic bit m_idle(int m);
    return (m_left[m] == 0) && (m_gap[m] == 0);
  endfunction

  function automatic bit m_ready(int m, int g, logic inj);
    return rst && !m_pend[m] && (m_idle(m) || (m_left[m] == 1 && g == 0 && !inj));
  endfunction

  task automatic load(int m, bit mark, logic [7:0] di);
    m_mark[m] = mark;
    m_item[m] = mark ? 32'b11010 : 32'(di);
    m_left[m] = mark ? 5 : 8;
  endtask

  task automatic model_step(int m, int g, logic vi, logic [7:0] di, logic inj);
    bit take;
    take = vi && m_ready(m, g, inj);
    if (m_left[m] > 0) begin
      m_left[m]--;
      if (m_left[m] == 0) begin
        if (m_mark[m] && m_cnt[m] < 255) m_cnt[m]++;
        if (g > 0) begin
          m_gap[m] = g;
          m_pend[m] = m_pend[m] | inj;
        end else if (m_pend[m] || inj) begin
          load(m, 1'b1, di);
          m_pend[m] = 0;
        end else if (take) begin
          load(m, 1'b0, di);
        end
      end else begin
        m_pend[m] = m_pend[m] | inj;
      end
    end else if (m_gap[m] > 0) begin
      m_gap[m]--;
      m_pend[m] = m_pend[m] | inj;
    end else if (m_pend[m]) begin
      load(m, 1'b1, di);
      m_pend[m] = 0;
    end else begin
      if (take) load(m, 1'b0, di);
      m_pend[m] = inj;
    end
  endtask

  task automatic check_model(int m, int g, logic inj, logic v, logic d, logic r,
                             logic b, logic [7:0] c);
    logic ev, ed;
    ev = (m_left[m] > 0);
    ed = ev ? m_item[m][m_left[m]-1] : 1'b0;
    chk($sformatf("m%0d valid_o", m), 32'(v), 32'(ev));
    chk($sformatf("m%0d data_o", m), 32'(d), 32'(ed));
    chk($sformatf("m%0d ready_o", m), 32'(r), 32'(m_ready(m, g, inj)));
    chk($sformatf("m%0d busy_o", m), 32'(b), 32'(!m_idle(m) || m_pend[m]));
    chk($sformatf("m%0d inj_count_o", m), 32'(c), 32'(m_cnt[m]));
  endtask

  // driver tasks: inputs change at the falling edge, outputs are checked 1ns later
  task automatic settle_and_check();
    #1;
    check_model(0, 0, bus0.inject_i, bus0.valid_o, bus0.data_o, bus0.ready_o,
                bus0.busy_o, bus0.inj_count_o);
    check_model(1, 2, bus2.inject_i, bus2.valid_o, bus2.data_o, bus2.ready_o,
                bus2.busy_o, bus2.inj_count_o);
    if (bus0.valid_o) col0 = {col0[6:0], bus0.data_o};
    if (m_left[0] == 1 && !m_mark[0]) begin
      if (exp_q.size() == 0) chk("m0 word scoreboard empty", 32'd1, 32'd0);
      else chk("m0 word", 32'(col0), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic advance();
    logic t0;
    t0 = bus0.valid_i && bus0.ready_o;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (t0) exp_q.push_back(bus0.data_i);
      model_step(0, 0, bus0.valid_i, bus0.data_i, bus0.inject_i);
      model_step(1, 2, bus2.valid_i, bus2.data_i, bus2.inject_i);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       vi;
    logic [7:0] di;
    logic       inj;
    logic       ev;
    logic       ed;
    logic       er;
    logic [7:0] ec;
  } vec_t;

  vec_t        vecs[18];
  logic [7:0]  wd;
  logic [4:0]  mk;
  logic [20:0] stream, exp_stream;
  logic [15:0] vh;
  logic [3:0]  bb;
  logic        acc;
  int          nv, acc_at, nwords;

  initial begin
    wd = 8'hD0;
    mk = 5'b11010;
    vecs[0] = '{1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    for (int k = 1; k <= 8; k++)
      vecs[k] = '{1'b0, 8'h00, 1'b0, 1'b1, wd[8-k], logic'(k == 8), 8'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    for (int k = 0; k < 5; k++)
      vecs[12+k] = '{1'b0, 8'h00, 1'b0, 1'b1, mk[4-k], logic'(k == 4), 8'd0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};

    rst = 1'b0;
    bus0.valid_i = 0; bus0.data_i = '0; bus0.inject_i = 0;
    bus2.valid_i = 0; bus2.data_i = '0; bus2.inject_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid_o", 32'(bus0.valid_o), 0);
    chk("reset data_o", 32'(bus0.data_o), 0);
    chk("reset ready_o", 32'(bus0.ready_o), 0);
    chk("reset busy_o", 32'(bus0.busy_o), 0);
    chk("reset inj_count_o", 32'(bus0.inj_count_o), 0);
    @(negedge clk);
    rst = 1'b1;

    // single word 0xD0, then a lone marker
    for (int i = 0; i < 18; i++) begin
      bus0.valid_i = vecs[i].vi; bus0.data_i = vecs[i].di; bus0.inject_i = vecs[i].inj;
      settle_and_check();
      chk($sformatf("vec%0d valid_o", i), 32'(bus0.valid_o), 32'(vecs[i].ev));
      chk($sformatf("vec%0d data_o", i), 32'(bus0.data_o), 32'(vecs[i].ed));
      chk($sformatf("vec%0d ready_o", i), 32'(bus0.ready_o), 32'(vecs[i].er));
      chk($sformatf("vec%0d inj_count_o", i), 32'(bus0.inj_count_o), 32'(vecs[i].ec));
      advance();
    end

    // two consecutive inject pulses give one marker
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      bus0.inject_i = (i < 2);
      settle_and_check();
      nv += int'(bus0.valid_o);
      advance();
    end
    bus0.inject_i = 0;
    chk("dropped inject valid cycles", 32'(nv), 32'd5);
    chk("dropped inject count", 32'(bus0.inj_count_o), 32'd2);

    // inject during 0xFF with 0x00 waiting
    bus0.valid_i = 1; bus0.data_i = 8'hFF;
    settle_and_check();
    chk("midword accept 0xFF", 32'(bus0.ready_o), 32'd1);
    advance();
    bus0.data_i = 8'h00;
    stream = '0; nv = 0; acc_at = -1;
    for (int i = 0; i < 21; i++) begin
      bus0.inject_i = (i == 2);
      settle_and_check();
      stream = {stream[19:0], bus0.data_o};
      nv += int'(bus0.valid_o);
      acc = bus0.valid_i && bus0.ready_o;
      if (acc) acc_at = i;
      advance();
      if (acc) bus0.valid_i = 0;
    end
    bus0.inject_i = 0;
    exp_stream = {8'hFF, 5'b11010, 8'h00};
    chk("midword stream", 32'(stream), 32'(exp_stream));
    chk("midword valid cycles", 32'(nv), 32'd21);
    chk("midword 0x00 accept slot", 32'(acc_at), 32'd12);
    chk("midword count", 32'(bus0.inj_count_o), 32'd3);
    repeat (2) begin settle_and_check(); advance(); end

    // random traffic on the GAP=0 instance
    for (int i = 0; i < 600; i++) begin
      if (!bus0.valid_i && $urandom_range(0, 3) != 0) begin
        bus0.valid_i = 1;
        bus0.data_i  = 8'($urandom);
      end
      bus0.inject_i = ($urandom_range(0, 15) == 0);
      settle_and_check();
      acc = bus0.valid_i && bus0.ready_o;
      advance();
      if (acc) bus0.valid_i = 0;
    end
    bus0.valid_i = 0; bus0.inject_i = 0;
    for (int w = 0; w < 40 && !(m_idle(0) && !m_pend[0]); w++) begin
      settle_and_check(); advance();
    end
    settle_and_check();
    chk("random scoreboard drained", 32'(exp_q.size()), 32'd0);
    advance();

    // GAP=2: two words back to back, reset on bit 4 of the second
    bus2.valid_i = 1; bus2.data_i = 8'hA5; nwords = 0; vh = '0; bb = '0;
    for (int c = 0; c < 16; c++) begin
      settle_and_check();
      vh[c] = bus2.valid_o;
      if (c >= 12) bb = {bb[2:0], bus2.data_o};
      acc = bus2.valid_i && bus2.ready_o;
      if (c == 15) break;
      advance();
      if (acc) begin
        nwords++;
        if (nwords == 1) bus2.data_i = 8'h3C;
        else bus2.valid_i = 0;
      end
    end
    chk("gap valid_o history", 32'(vh), 32'hF1FE);
    chk("gap second word head", 32'(bb), 32'b0011);
    rst = 1'b0; bus2.valid_i = 0;
    #1;
    chk("abort valid_o", 32'(bus2.valid_o), 0);
    chk("abort data_o", 32'(bus2.data_o), 0);
    chk("abort ready_o", 32'(bus2.ready_o), 0);
    chk("abort busy_o", 32'(bus2.busy_o), 0);
    chk("abort inj_count_o", 32'(bus2.inj_count_o), 0);
    chk("abort m0 inj_count_o", 32'(bus0.inj_count_o), 0);
    model_reset();
    advance();
    settle_and_check();
    advance();
    rst = 1'b1;
    settle_and_check();
    chk("ready after release", 32'(bus2.ready_o), 32'd1);
    advance();

    // 260 markers: count saturates at 255
    for (int k = 0; k < 260; k++) begin
      bus0.inject_i = 1;
      settle_and_check();
      advance();
      bus0.inject_i = 0;
      for (int w = 0; w < 20 && !(m_idle(0) && !m_pend[0]); w++) begin
        settle_and_check(); advance();
      end
    end
    settle_and_check();
    chk("saturated count", 32'(bus0.inj_count_o), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
